// File: rtl/col_norm_stream.sv
// Streaming column squared-norm accumulator: takes an N x N matrix one row at a time,
// then holds per-column saturating norms, the argmin column and a saturation flag.
module col_norm_stream #(
   parameter int N           = 8,
   parameter int WL          = 16,
   parameter int FWL         = 12,
   parameter int COLNORM_WL  = 16,
   parameter int COLNORM_FWL = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N*WL-1:0]         in_row,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [N*COLNORM_WL-1:0] colnorm,
   output logic [((N > 2) ? $clog2(N) : 1)-1:0] min_idx,
   output logic                    sat_flag
);

   localparam int IW = (N > 2) ? $clog2(N) : 1;
   localparam int SH = FWL - COLNORM_FWL;
   localparam int PW = 2 * WL;
   localparam int SW = ((PW > COLNORM_WL) ? PW : COLNORM_WL) + 1;
   localparam logic [COLNORM_WL-1:0] MAXV = '1;

   typedef enum logic {ACC, HOLD} state_t;

   state_t                  state;
   logic [IW-1:0]           cnt;
   logic                    sticky;
   logic [COLNORM_WL-1:0]   acc     [N];
   logic [COLNORM_WL-1:0]   acc_nx  [N];
   logic signed [WL-1:0]    e_sh    [N];
   logic signed [PW-1:0]    e_ext   [N];
   logic signed [PW-1:0]    prod    [N];
   logic [PW-1:0]           term    [N];
   logic [SW-1:0]           sum     [N];
   logic                    clamp_any;
   logic [N*COLNORM_WL-1:0] colnorm_nx;
   logic [IW-1:0]           min_nx;
   logic [COLNORM_WL-1:0]   minv;

   // Per-column contribution of the row on in_row, folded into the accumulators with clamping.
   always_comb begin
      clamp_any  = 1'b0;
      colnorm_nx = '0;
      for (int unsigned j = 0; j < N; j++) begin
         e_sh[j]  = $signed(in_row[j*WL +: WL]) >>> SH;
         e_ext[j] = PW'(e_sh[j]);
         prod[j]  = e_ext[j] * e_ext[j];
         term[j]  = $unsigned(prod[j]) >> COLNORM_FWL;
         sum[j]   = SW'(acc[j]) + SW'(term[j]);
         if (sum[j] > SW'(MAXV)) begin
            acc_nx[j] = MAXV;
            clamp_any = 1'b1;
         end else begin
            acc_nx[j] = sum[j][COLNORM_WL-1:0];
         end
         colnorm_nx[j*COLNORM_WL +: COLNORM_WL] = acc_nx[j];
      end
   end

   // Strict less-than keeps the lowest index on ties.
   always_comb begin
      min_nx = '0;
      minv   = acc_nx[0];
      for (int unsigned j = 1; j < N; j++) begin
         if (acc_nx[j] < minv) begin
            minv   = acc_nx[j];
            min_nx = IW'(j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACC;
         cnt       <= '0;
         sticky    <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         colnorm   <= '0;
         min_idx   <= '0;
         sat_flag  <= 1'b0;
         for (int unsigned j = 0; j < N; j++) acc[j] <= '0;
      end else begin
         case (state)
            ACC: begin
               if (in_valid) begin
                  acc    <= acc_nx;
                  sticky <= sticky | clamp_any;
                  if (cnt == IW'(N - 1)) begin
                     cnt       <= '0;
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     colnorm   <= colnorm_nx;
                     min_idx   <= min_nx;
                     sat_flag  <= sticky | clamp_any;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= ACC;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  sticky    <= 1'b0;
                  colnorm   <= '0;
                  min_idx   <= '0;
                  sat_flag  <= 1'b0;
                  for (int unsigned j = 0; j < N; j++) acc[j] <= '0;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_col_norm_stream.sv
// Bench for col_norm_stream: directed table of fill-pattern matrices, random matrices
// against an arithmetic reference model, plus stall and mid-matrix reset sequences.
module tb_col_norm_stream;

   localparam int N    = 8;
   localparam int WL   = 16;
   localparam int FWL  = 12;
   localparam int CWL  = 16;
   localparam int CFWL = 10;
   localparam int IW   = 3;

   typedef logic [WL-1:0] mat_t  [N][N];
   typedef int unsigned   norm_t [N];
   typedef struct {
      logic [WL-1:0] fill;
      int            zero_col;
      int unsigned   exp_norm;
      int            exp_min;
      bit            exp_sat;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [N*WL-1:0]  in_row;
   logic             out_valid;
   logic             out_ready;
   logic [N*CWL-1:0] colnorm;
   logic [IW-1:0]    min_idx;
   logic             sat_flag;

   int vectors    = 0;
   int miscompares = 0;

   col_norm_stream #(.N(N), .WL(WL), .FWL(FWL), .COLNORM_WL(CWL), .COLNORM_FWL(CFWL)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
      .out_valid(out_valid), .out_ready(out_ready), .colnorm(colnorm), .min_idx(min_idx),
      .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [N*CWL-1:0] act, input logic [N*CWL-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Floor-shift, square, floor-shift and saturating accumulate, in plain integer arithmetic.
   task automatic model(input mat_t m, output norm_t nm, output int mi, output bit sat);
      longint d, v, s, t, a;
      d   = longint'(1) << (FWL - CFWL);
      sat = 1'b0;
      for (int j = 0; j < N; j++) begin
         a = 0;
         for (int r = 0; r < N; r++) begin
            v = longint'($signed(m[r][j]));
            s = (v >= 0) ? v / d : -((-v + d - 1) / d);
            t = (s * s) / (longint'(1) << CFWL);
            a = a + t;
            if (a > 65535) begin
               a   = 65535;
               sat = 1'b1;
            end
         end
         nm[j] = int'(a);
      end
      mi = 0;
      for (int j = 1; j < N; j++) if (nm[j] < nm[mi]) mi = j;
   endtask

   task automatic run_matrix(input string tag, input mat_t m, input norm_t en, input int emi,
                             input bit esat, input bit bubbles, input int stall);
      logic [N*CWL-1:0] exp_packed;
      for (int j = 0; j < N; j++) exp_packed[j*CWL +: CWL] = en[j][CWL-1:0];
      for (int r = 0; r < N; r++) begin
         if (bubbles) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               in_valid = 1'b0;
               in_row   = {$urandom, $urandom, $urandom, $urandom};
            end
         end
         @(negedge clk);
         if (r == N - 1) check({tag, " out_valid before last row"}, out_valid, 0);
         in_valid = 1'b1;
         for (int j = 0; j < N; j++) in_row[j*WL +: WL] = m[r][j];
      end
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, " out_valid"}, out_valid, 1);
      check({tag, " in_ready in HOLD"}, in_ready, 0);
      check({tag, " colnorm"}, colnorm, exp_packed);
      check({tag, " min_idx"}, min_idx, emi);
      check({tag, " sat_flag"}, sat_flag, esat);
      for (int c = 0; c < stall; c++) begin
         in_valid  = 1'b1;
         in_row    = {$urandom, $urandom, $urandom, $urandom};
         out_ready = 1'b0;
         @(negedge clk);
         check({tag, " stall out_valid"}, out_valid, 1);
         check({tag, " stall in_ready"}, in_ready, 0);
         check({tag, " stall colnorm"}, colnorm, exp_packed);
         check({tag, " stall min_idx"}, min_idx, emi);
         check({tag, " stall sat_flag"}, sat_flag, esat);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " out_valid after release"}, out_valid, 0);
      check({tag, " in_ready after release"}, in_ready, 1);
      check({tag, " colnorm cleared"}, colnorm, 0);
      check({tag, " sat_flag cleared"}, sat_flag, 0);
   endtask

   task automatic fill_matrix(input logic [WL-1:0] f, input int zc, output mat_t m);
      for (int r = 0; r < N; r++)
         for (int j = 0; j < N; j++) m[r][j] = (j == zc) ? '0 : f;
   endtask

   vec_t  tbl [6];
   mat_t  m;
   norm_t en;
   int    emi;
   bit    esat;

   initial begin
      tbl[0] = '{16'h1000, -1, 32'h2000, 0, 1'b0};
      tbl[1] = '{16'hF000, -1, 32'h2000, 0, 1'b0};
      tbl[2] = '{16'h0001, -1, 32'h0000, 0, 1'b0};
      tbl[3] = '{16'h1000,  3, 32'h2000, 3, 1'b0};
      tbl[4] = '{16'h7FFF, -1, 32'hFFFF, 0, 1'b1};
      tbl[5] = '{16'h1000, -1, 32'h2000, 0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_row = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset colnorm", colnorm, 0);
      check("reset min_idx", min_idx, 0);
      check("reset sat_flag", sat_flag, 0);

      for (int i = 0; i < 6; i++) begin
         fill_matrix(tbl[i].fill, tbl[i].zero_col, m);
         for (int j = 0; j < N; j++) en[j] = (j == tbl[i].zero_col) ? 0 : tbl[i].exp_norm;
         run_matrix($sformatf("table%0d", i), m, en, tbl[i].exp_min, tbl[i].exp_sat, 1'b0, 0);
      end

      // Held result must survive back-pressure with rows offered, and no row may leak in.
      fill_matrix(16'h0800, -1, m);
      for (int j = 0; j < N; j++) en[j] = 32'h0800;
      run_matrix("stall", m, en, 0, 1'b0, 1'b0, 5);
      fill_matrix(16'h1000, -1, m);
      for (int j = 0; j < N; j++) en[j] = 32'h2000;
      run_matrix("after stall", m, en, 0, 1'b0, 1'b0, 0);

      // Three large rows then reset (with a row offered in the reset cycle): must be discarded.
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_row   = {N{16'h7FFF}};
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      check("mid reset out_valid", out_valid, 0);
      check("mid reset in_ready", in_ready, 1);
      fill_matrix(16'h1000, -1, m);
      for (int j = 0; j < N; j++) en[j] = 32'h2000;
      run_matrix("post reset", m, en, 0, 1'b0, 1'b0, 0);

      for (int k = 0; k < 20; k++) begin
         for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++)
               case (k % 3)
                  0:       m[r][j] = WL'($urandom);
                  1:       m[r][j] = WL'($urandom_range(0, 7)) - WL'(3);
                  default: m[r][j] = WL'($urandom_range(0, 16'h1FFF)) - WL'(16'h1000);
               endcase
         model(m, en, emi, esat);
         run_matrix($sformatf("rand%0d", k), m, en, emi, esat, 1'b1, k % 4);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
